// File: rtl/audio_pkg.sv
// Shared constants and types for the codec audio path.
// The line-in deserializer and the DAC serializer both import this package.
package audio_pkg;

   localparam int   AUD_DATA_W     = 16;
   localparam logic LRCK_LEFT      = 1'b1;
   localparam int   UNDERRUN_CNT_W = 8;

   typedef enum logic [1:0] {
      WAIT_SYNC,
      LEFT,
      RIGHT
   } dac_state_t;

endpackage

// File: rtl/aud_sync_edge.sv
// Brings an asynchronous codec clock into CLOCK_50 and reports its edges.
// An edge on din is reported SYNC_STAGES+1 CLOCK_50 edges after it happens.
module aud_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLOCK_50,
   input  logic RST,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge CLOCK_50) begin
      if (!RST) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Both terms come straight from flops, so the pulses are glitch-free.
   assign rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/audio_dac_serializer.sv
// Left-justified DAC serializer: one-deep sample-pair buffer, MSB-first shifter
// locked to the codec BCLK/LRCK (sampled as data), and underrun reporting.
module audio_dac_serializer
   import audio_pkg::*;
#(
   parameter int DATA_W      = AUD_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      CLOCK_50,
   input  logic                      RST,
   input  logic                      AUD_BCLK,
   input  logic                      AUD_DACLRCK,
   input  logic [DATA_W-1:0]         sample_l,
   input  logic [DATA_W-1:0]         sample_r,
   input  logic                      sample_valid,
   output logic                      sample_ready,
   output logic                      AUD_DACDAT,
   output logic                      frame_strobe,
   output logic                      underrun,
   output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

   localparam int CNT_W = $clog2(DATA_W);

   logic bclk_rise, bclk_fall;
   logic lr_rise, lr_fall;
   logic left_edge, right_edge;
   logic accept;

   dac_state_t                state_q, state_d;
   logic [DATA_W-1:0]         hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic                      hold_full_q, hold_full_d;
   logic [DATA_W-1:0]         active_l_q, active_l_d, active_r_q, active_r_d;
   logic [DATA_W-1:0]         shreg_q, shreg_d;
   logic [CNT_W-1:0]          bitcnt_q, bitcnt_d;
   logic                      started_q, started_d;
   logic                      dacdat_q, dacdat_d;
   logic                      strobe_q, strobe_d;
   logic                      underrun_q, underrun_d;
   logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;
   logic                      ready_q, ready_d;

   aud_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
      .CLOCK_50 (CLOCK_50),
      .RST      (RST),
      .din      (AUD_BCLK),
      .rise     (bclk_rise),
      .fall     (bclk_fall)
   );

   aud_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
      .CLOCK_50 (CLOCK_50),
      .RST      (RST),
      .din      (AUD_DACLRCK),
      .rise     (lr_rise),
      .fall     (lr_fall)
   );

   assign left_edge  = (LRCK_LEFT == 1'b1) ? lr_rise : lr_fall;
   assign right_edge = (LRCK_LEFT == 1'b1) ? lr_fall : lr_rise;
   assign accept     = sample_valid & ready_q;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_d     = state_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      hold_full_d = hold_full_q;
      active_l_d  = active_l_q;
      active_r_d  = active_r_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      started_d   = started_q;
      strobe_d    = 1'b0;
      underrun_d  = 1'b0;
      ucnt_d      = ucnt_q;

      // NOTE: an LRCK edge takes priority; a BCLK fall in the same cycle is not a shift.
      if (left_edge) begin
         bitcnt_d = '0;
         if (state_q == LEFT) begin
            shreg_d = active_l_q;
         end else begin
            strobe_d  = 1'b1;
            state_d   = LEFT;
            started_d = 1'b1;
            if (hold_full_q) begin
               active_l_d  = hold_l_q;
               active_r_d  = hold_r_q;
               shreg_d     = hold_l_q;
               hold_full_d = 1'b0;
            end else if (started_q) begin
               shreg_d    = active_l_q;
               underrun_d = 1'b1;
               if (ucnt_q != '1) ucnt_d = ucnt_q + 1'b1;
            end else begin
               shreg_d = '0;
            end
         end
      end else if (right_edge && state_q != WAIT_SYNC) begin
         shreg_d  = active_r_q;
         bitcnt_d = '0;
         state_d  = RIGHT;
      end else if (bclk_fall && state_q != WAIT_SYNC) begin
         if (bitcnt_q < CNT_W'(DATA_W-1)) begin
            shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
            bitcnt_d = bitcnt_q + 1'b1;
         end else begin
            shreg_d = '0;
         end
      end

      // A pair accepted on the same cycle as a left load is kept for the next frame.
      if (accept) begin
         hold_l_d    = sample_l;
         hold_r_d    = sample_r;
         hold_full_d = 1'b1;
      end

      ready_d  = ~hold_full_d;
      dacdat_d = (state_q != WAIT_SYNC) & shreg_q[DATA_W-1];
   end

   always_ff @(posedge CLOCK_50) begin
      // NOTE: the sample buffers are plain registers, so they are cleared with the rest.
      if (!RST) begin
         state_q     <= WAIT_SYNC;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         hold_full_q <= 1'b0;
         active_l_q  <= '0;
         active_r_q  <= '0;
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         started_q   <= 1'b0;
         dacdat_q    <= 1'b0;
         strobe_q    <= 1'b0;
         underrun_q  <= 1'b0;
         ucnt_q      <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         hold_full_q <= hold_full_d;
         active_l_q  <= active_l_d;
         active_r_q  <= active_r_d;
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         started_q   <= started_d;
         dacdat_q    <= dacdat_d;
         strobe_q    <= strobe_d;
         underrun_q  <= underrun_d;
         ucnt_q      <= ucnt_d;
         ready_q     <= ready_d;
      end
   end

   assign sample_ready = ready_q;
   assign AUD_DACDAT   = dacdat_q;
   assign frame_strobe = strobe_q;
   assign underrun     = underrun_q;
   assign underrun_cnt = ucnt_q;

   // bclk_rise is available for a future rising-edge format; keep it observed.
   logic unused_ok;
   assign unused_ok = bclk_rise;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: word-level reference model of frames, buffer
// and underruns, compared every CLOCK_50 cycle, plus literal frame captures.
module tb_audio_dac_serializer;

   localparam int DW = 16;
   localparam int S  = 2;

   localparam int P_IDLE = 0;
   localparam int P_ONE  = 1;
   localparam int P_CONT = 2;
   localparam int P_RAND = 3;

   logic          CLOCK_50 = 1'b0;
   logic          RST = 1'b0;
   logic          AUD_BCLK = 1'b1;
   logic          AUD_DACLRCK = 1'b0;
   logic [DW-1:0] sample_l = '0;
   logic [DW-1:0] sample_r = '0;
   logic          sample_valid = 1'b0;
   logic          sample_ready;
   logic          AUD_DACDAT;
   logic          frame_strobe;
   logic          underrun;
   logic [7:0]    underrun_cnt;

   always #10 CLOCK_50 = ~CLOCK_50;

   audio_dac_serializer dut (
      .CLOCK_50     (CLOCK_50),
      .RST          (RST),
      .AUD_BCLK     (AUD_BCLK),
      .AUD_DACLRCK  (AUD_DACLRCK),
      .sample_l     (sample_l),
      .sample_r     (sample_r),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .AUD_DACDAT   (AUD_DACDAT),
      .frame_strobe (frame_strobe),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (word + bit index per frame) ----------------
   typedef enum {M_WAIT, M_LEFT, M_RIGHT} m_state_e;
   m_state_e      m_state = M_WAIT;
   logic [DW-1:0] m_word = '0, m_act_l = '0, m_act_r = '0, m_hold_l = '0, m_hold_r = '0;
   int            m_idx = 0, m_cnt = 0;
   bit            m_hold_full = 0, m_started = 0, m_ready = 0, m_dac = 0;
   bit            m_strobe = 0, m_und = 0, m_acc = 0, m_live = 0;
   bit            lr_hist [0:S+1];
   bit            bk_hist [0:S+1];

   task automatic model_step();
      bit lr_r, lr_f, bk_f;
      m_dac    = (m_state != M_WAIT && m_idx < DW) ? m_word[DW-1-m_idx] : 1'b0;
      m_acc    = 0;
      m_strobe = 0;
      m_und    = 0;
      if (!RST) begin
         m_state = M_WAIT; m_word = '0; m_idx = 0; m_cnt = 0;
         m_act_l = '0; m_act_r = '0; m_hold_l = '0; m_hold_r = '0;
         m_hold_full = 0; m_started = 0; m_ready = 0; m_dac = 0;
         for (int i = 0; i <= S + 1; i++) begin
            lr_hist[i] = 0;
            bk_hist[i] = 0;
         end
      end else begin
         for (int i = S + 1; i > 0; i--) begin
            lr_hist[i] = lr_hist[i-1];
            bk_hist[i] = bk_hist[i-1];
         end
         lr_hist[0] = AUD_DACLRCK;
         bk_hist[0] = AUD_BCLK;
         lr_r = lr_hist[S] && !lr_hist[S+1];
         lr_f = !lr_hist[S] && lr_hist[S+1];
         bk_f = !bk_hist[S] && bk_hist[S+1];
         if (lr_r) begin
            m_idx = 0;
            if (m_state == M_LEFT) begin
               m_word = m_act_l;
            end else begin
               m_strobe = 1;
               if (m_hold_full) begin
                  m_act_l = m_hold_l;
                  m_act_r = m_hold_r;
                  m_hold_full = 0;
               end else if (m_started) begin
                  m_und = 1;
                  if (m_cnt < 255) m_cnt++;
               end
               m_word    = m_started || m_strobe && m_act_l != '0 ? m_act_l : '0;
               m_state   = M_LEFT;
               m_started = 1;
            end
         end else if (lr_f && m_state != M_WAIT) begin
            m_word  = m_act_r;
            m_idx   = 0;
            m_state = M_RIGHT;
         end else if (bk_f && m_state != M_WAIT) begin
            if (m_idx < DW) m_idx++;
         end
         if (sample_valid && m_ready) begin
            m_hold_l    = sample_l;
            m_hold_r    = sample_r;
            m_hold_full = 1;
            m_acc       = 1;
         end
         m_ready = !m_hold_full;
      end
      m_live = 1;
   endtask

   initial forever begin
      @(posedge CLOCK_50);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   int strobe_seen = 0;
   int und_seen = 0;

   initial forever begin
      @(negedge CLOCK_50);
      if (m_live) begin
         check("dacdat",       32'(AUD_DACDAT),   32'(m_dac));
         check("frame_strobe", 32'(frame_strobe), 32'(m_strobe));
         check("underrun",     32'(underrun),     32'(m_und));
         check("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
         check("sample_ready", 32'(sample_ready), 32'(m_ready));
         if (frame_strobe) strobe_seen++;
         if (underrun) und_seen++;
      end
   end

   // ---------------- stimulus ----------------
   int          p_mode = P_IDLE;
   logic [31:0] cap = '0, cap_left = '0, cap_right = '0;

   task automatic tick();
      @(negedge CLOCK_50);
      case (p_mode)
         P_ONE: if (m_acc) begin p_mode = P_IDLE; sample_valid = 1'b0; end
                else sample_valid = 1'b1;
         P_CONT: begin
            if (m_acc || !sample_valid) begin
               sample_l = 16'($urandom);
               sample_r = 16'($urandom);
            end
            sample_valid = 1'b1;
         end
         P_RAND: begin
            sample_valid = ($urandom_range(0, 2) == 0);
            sample_l = 16'($urandom);
            sample_r = 16'($urandom);
         end
         default: sample_valid = 1'b0;
      endcase
   endtask

   task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
      sample_l = l;
      sample_r = r;
      sample_valid = 1'b1;
      p_mode = P_ONE;
      for (int i = 0; i < 20 && p_mode != P_IDLE; i++) tick();
      check("offer_accepted", 32'(p_mode), 32'(P_IDLE));
   endtask

   task automatic drive_half(input bit lr, input int nbclk, input bit glitch, input bit coinc,
                             input logic [DW-1:0] cl, input logic [DW-1:0] cr, input int rst_slot);
      cap = '0;
      for (int b = 0; b < nbclk; b++) begin
         AUD_BCLK = 1'b0;
         if (b == 0) AUD_DACLRCK = lr;
         if (glitch && (b == 3 || b == 8)) begin
            AUD_DACLRCK = 1'b1; tick(); tick();
            AUD_DACLRCK = 1'b0; tick(); tick();
         end else if (coinc && b == 0) begin
            tick(); tick();
            sample_l = cl; sample_r = cr; sample_valid = 1'b1; p_mode = P_ONE;
            tick(); tick();
         end else if (rst_slot == b) begin
            tick();
            RST = 1'b0;
            tick();
            check("rst_mid_dacdat",   32'(AUD_DACDAT),   32'd0);
            check("rst_mid_strobe",   32'(frame_strobe), 32'd0);
            check("rst_mid_underrun", 32'(underrun),     32'd0);
            check("rst_mid_cnt",      32'(underrun_cnt), 32'd0);
            check("rst_mid_ready",    32'(sample_ready), 32'd0);
            tick();
            RST = 1'b1;
            tick();
         end else begin
            repeat (4) tick();
         end
         AUD_BCLK = 1'b1;
         cap = {cap[30:0], AUD_DACDAT};
         repeat (4) tick();
      end
   endtask

   task automatic frame(input int nbclk, input bit glitch_r, input bit coinc,
                        input logic [DW-1:0] cl, input logic [DW-1:0] cr, input int rst_slot);
      drive_half(1'b1, nbclk, 1'b0, coinc, cl, cr, -1);
      cap_left = cap;
      drive_half(1'b0, nbclk, glitch_r, 1'b0, '0, '0, rst_slot);
      cap_right = cap;
   endtask

   initial begin
      int base;
      RST = 1'b0;
      repeat (4) tick();
      check("reset_dacdat",   32'(AUD_DACDAT),   32'd0);
      check("reset_strobe",   32'(frame_strobe), 32'd0);
      check("reset_underrun", 32'(underrun),     32'd0);
      check("reset_cnt",      32'(underrun_cnt), 32'd0);
      check("reset_ready",    32'(sample_ready), 32'd0);
      RST = 1'b1;
      tick(); tick();
      check("ready_after_release", 32'(sample_ready), 32'd1);

      // Preloaded pair, 32 BCLK per channel.
      offer(16'hA5C3, 16'h0F01);
      tick();
      check("ready_when_full", 32'(sample_ready), 32'd0);
      base = strobe_seen;
      frame(32, 0, 0, '0, '0, -1);
      check("cap_left_a5c3",  cap_left,  32'hA5C3_0000);
      check("cap_right_0f01", cap_right, 32'h0F01_0000);
      check("one_strobe",     32'(strobe_seen - base), 32'd1);

      // Continuous producer over 100 frames.
      p_mode = P_CONT;
      repeat (100) frame(16, 0, 0, '0, '0, -1);
      p_mode = P_IDLE;
      check("no_underrun_cont", 32'(underrun_cnt), 32'd0);
      frame(16, 0, 0, '0, '0, -1);

      // Single pair then starve.
      offer(16'h7FFF, 16'h8000);
      frame(16, 0, 0, '0, '0, -1);
      check("cap_left_7fff", cap_left, 32'h0000_7FFF);
      base = und_seen;
      repeat (3) frame(16, 0, 0, '0, '0, -1);
      check("cnt_after_3",    32'(underrun_cnt), 32'd3);
      check("und_pulses_3",   32'(und_seen - base), 32'd3);
      check("repeat_left",    cap_left,  32'h0000_7FFF);
      check("repeat_right",   cap_right, 32'h0000_8000);

      // Accept on the very cycle of lr_rise with the buffer empty.
      frame(16, 0, 1, 16'h1234, 16'h5678, -1);
      check("coinc_old_left", cap_left, 32'h0000_7FFF);
      check("coinc_cnt",      32'(underrun_cnt), 32'd4);
      frame(16, 0, 0, '0, '0, -1);
      check("coinc_new_left",  cap_left,  32'h0000_1234);
      check("coinc_new_right", cap_right, 32'h0000_5678);
      check("coinc_cnt_hold",  32'(underrun_cnt), 32'd4);

      // Saturation with short frames.
      repeat (260) frame(4, 0, 0, '0, '0, -1);
      check("cnt_saturated", 32'(underrun_cnt), 32'd255);

      // Random producer, frame lengths and glitches.
      p_mode = P_RAND;
      repeat (20) frame($urandom_range(16, 24), ($urandom_range(0, 3) == 0), 0, '0, '0, -1);
      p_mode = P_IDLE;
      tick();
      frame(16, 0, 0, '0, '0, -1);

      // Glitch pulses inside a right frame, then normal framing.
      offer(16'hABCD, 16'h1357);
      frame(32, 0, 0, '0, '0, -1);
      frame(32, 1, 0, '0, '0, -1);
      frame(32, 0, 0, '0, '0, -1);
      check("post_glitch_left",  cap_left,  32'hABCD_0000);
      check("post_glitch_right", cap_right, 32'h1357_0000);

      // Reset mid right frame with LRCK low.
      frame(32, 0, 0, '0, '0, 5);
      base = und_seen;
      frame(32, 0, 0, '0, '0, -1);
      check("first_after_rst_zero", cap_left, 32'h0000_0000);
      check("first_after_rst_noun", 32'(und_seen - base), 32'd0);
      frame(32, 0, 0, '0, '0, -1);
      check("second_after_rst_cnt", 32'(underrun_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
